// File: rtl/multi_signal_counter_pkg.sv
// Shared definitions for the multi-channel debounced event counter:
// per-channel FSM state encoding and the wrap/saturate mode constants.
package multi_signal_counter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        INCREMENT = 2'd2,
        HOLD      = 2'd3
    } ch_state_e;

    localparam int WRAP = 0;
    localparam int SAT  = 1;

endpackage

// File: rtl/signal_counter_ch.sv
// One channel: debounce FSM that qualifies high pulses of sig_i, plus the
// terminal-count counter with clear/enable priority and a one-cycle tc pulse.
module signal_counter_ch
    import multi_signal_counter_pkg::*;
#(
    parameter int W        = 4,
    parameter int DEBOUNCE = 1,
    parameter int LIMIT    = 2**W-1,
    parameter int SATURATE = WRAP
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         sig_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         tc_o,
    output ch_state_e    state_o
);

    localparam logic [W-1:0] LIM           = W'(LIMIT);
    localparam logic [7:0]   DEB           = 8'(DEBOUNCE);
    localparam bit           HOLD_AT_LIMIT = (SATURATE == SAT);

    ch_state_e    state_q;
    logic [7:0]   deb_q;
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         tc_q;
    logic         tc_d;

    // Clear beats enable beats increment; an event that loses is simply dropped.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (state_q == INCREMENT && en_i) begin
            if (count_q < LIM) begin
                count_d = count_q + W'(1);
                tc_d    = (count_d == LIM);
            end else if (!HOLD_AT_LIMIT) begin
                count_d = '0;
            end
        end
    end

    // Reset parks in HOLD so a line already high is ignored until it drops.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= HOLD;
            deb_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            case (state_q)
                IDLE: begin
                    if (sig_i) begin
                        if (DEB == 8'd1) begin
                            state_q <= INCREMENT;
                        end else begin
                            state_q <= ARM;
                            deb_q   <= 8'd1;
                        end
                    end
                end
                ARM: begin
                    if (!sig_i) begin
                        state_q <= IDLE;
                        deb_q   <= '0;
                    end else if (deb_q + 8'd1 == DEB) begin
                        state_q <= INCREMENT;
                        deb_q   <= '0;
                    end else begin
                        deb_q <= deb_q + 8'd1;
                    end
                end
                INCREMENT: state_q <= sig_i ? HOLD : IDLE;
                HOLD: begin
                    if (!sig_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign state_o = state_q;

endmodule

// File: rtl/multi_signal_counter.sv
// N independent debounced rising-event counters sharing one enable; counts are
// packed channel i at [i*W +: W], channel FSM states at [2*i +: 2] of dbg_state.
module multi_signal_counter
    import multi_signal_counter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int DEBOUNCE = 1,
    parameter int LIMIT    = 2**W-1,
    parameter int SATURATE = WRAP
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   signal,
    input  logic [N-1:0]   clr,
    output logic [N*W-1:0] count,
    output logic [N-1:0]   tc,
    output logic [2*N-1:0] dbg_state
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        signal_counter_ch #(
            .W        (W),
            .DEBOUNCE (DEBOUNCE),
            .LIMIT    (LIMIT),
            .SATURATE (SATURATE)
        ) u_ch (
            .pclk    (pclk),
            .rst     (rst),
            .en_i    (en),
            .sig_i   (signal[i]),
            .clr_i   (clr[i]),
            .count_o (count[i*W +: W]),
            .tc_o    (tc[i]),
            .state_o (dbg_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_multi_signal_counter.sv
// Scenario bench for multi_signal_counter: four instances cover the default,
// debounced, wrapping and saturating configurations.
module tb_multi_signal_counter;

    logic        pclk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  sig_a, sig_d, sig_w, sig_s;
    logic [3:0]  clr_a, clr_0;
    logic [15:0] cnt_a, cnt_d, cnt_w, cnt_s;
    logic [3:0]  tc_a, tc_d, tc_w, tc_s;
    logic [7:0]  dbg_a, dbg_d, dbg_w, dbg_s;

    logic [19:0] exp_q[$];
    logic [19:0] exp_v;
    logic [19:0] obs_v;
    int          errors = 0;
    int          checks = 0;

    always #5 pclk = ~pclk;

    multi_signal_counter dut_a (
        .pclk(pclk), .rst(rst), .en(en), .signal(sig_a), .clr(clr_a),
        .count(cnt_a), .tc(tc_a), .dbg_state(dbg_a));

    multi_signal_counter #(.DEBOUNCE(3)) dut_d (
        .pclk(pclk), .rst(rst), .en(en), .signal(sig_d), .clr(clr_0),
        .count(cnt_d), .tc(tc_d), .dbg_state(dbg_d));

    multi_signal_counter #(.LIMIT(9), .SATURATE(0)) dut_w (
        .pclk(pclk), .rst(rst), .en(en), .signal(sig_w), .clr(clr_0),
        .count(cnt_w), .tc(tc_w), .dbg_state(dbg_w));

    multi_signal_counter #(.LIMIT(9), .SATURATE(1)) dut_s (
        .pclk(pclk), .rst(rst), .en(en), .signal(sig_s), .clr(clr_0),
        .count(cnt_s), .tc(tc_s), .dbg_state(dbg_s));

    task automatic do_reset();
        rst   = 1'b0;
        en    = 1'b1;
        sig_a = '0; sig_d = '0; sig_w = '0; sig_s = '0;
        clr_a = '0; clr_0 = '0;
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        en    = 1'b1;
        sig_a = 4'hF; sig_d = 4'hF; sig_w = 4'hF; sig_s = 4'hF;
        clr_a = '0; clr_0 = '0;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(20'h0);
            @(negedge pclk);
            obs_v = {tc_a, cnt_a};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            checks++;
            if (dbg_a !== 8'hFF) begin
                errors++;
                $display("FAIL reset_state c=%0d got=%h exp=ff", c, dbg_a);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            sig_a = (c < 10 || c >= 12) ? 4'hF : 4'h0;
            exp_q.push_back((c == 13) ? 20'h01111 : 20'h00000);
            @(negedge pclk);
            obs_v = {tc_a, cnt_a};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_release c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
        checks++;
        if ({tc_w, cnt_w, tc_s, cnt_s} !== 40'h0) begin
            errors++;
            $display("FAIL reset_other got=%h exp=0", {tc_w, cnt_w, tc_s, cnt_s});
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            sig_a = (c < 5) ? 4'h1 : 4'h0;
            exp_q.push_back((c >= 1) ? 20'h00001 : 20'h00000);
            @(negedge pclk);
            obs_v = {tc_a, cnt_a};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL latency c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_debounce();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c < 5) sig_d = (c < 2) ? 4'h1 : 4'h0;
            else       sig_d = (c - 5 < 3) ? 4'h1 : 4'h0;
            exp_q.push_back((c >= 8) ? 20'h00001 : 20'h00000);
            @(negedge pclk);
            obs_v = {tc_d, cnt_d};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL debounce c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            sig_w = (c % 2 == 0) ? 4'h1 : 4'h0;
            if (c % 2 == 1) n++;
            exp_q.push_back({3'b000, (c % 2 == 1 && n == 9), 12'h000, 4'(n % 10)});
            @(negedge pclk);
            obs_v = {tc_w, cnt_w};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL wrap c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_saturate();
        int n;
        int tc_seen;
        do_reset();
        n = 0;
        tc_seen = 0;
        for (int c = 0; c < 24; c++) begin
            sig_s = (c % 2 == 0) ? 4'h1 : 4'h0;
            if (c % 2 == 1) n++;
            exp_q.push_back({3'b000, (c % 2 == 1 && n == 9), 12'h000, 4'((n > 9) ? 9 : n)});
            @(negedge pclk);
            obs_v = {tc_s, cnt_s};
            exp_v = exp_q.pop_front();
            if (tc_s[0]) tc_seen++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL saturate c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
        checks++;
        if (tc_seen !== 1) begin
            errors++;
            $display("FAIL saturate_tc_count got=%0d exp=1", tc_seen);
        end
    endtask

    task automatic test_priority();
        logic [3:0]  p_sig[13];
        logic [3:0]  p_clr[13];
        logic        p_en[13];
        logic [15:0] p_exp[13];
        do_reset();
        // clear coincident with the end of INCREMENT on channel 1
        p_sig[0]  = 4'h2; p_clr[0]  = 4'h0; p_en[0]  = 1'b1; p_exp[0]  = 16'h0000;
        p_sig[1]  = 4'h0; p_clr[1]  = 4'h0; p_en[1]  = 1'b1; p_exp[1]  = 16'h0010;
        p_sig[2]  = 4'h2; p_clr[2]  = 4'h0; p_en[2]  = 1'b1; p_exp[2]  = 16'h0010;
        p_sig[3]  = 4'h0; p_clr[3]  = 4'h2; p_en[3]  = 1'b1; p_exp[3]  = 16'h0000;
        // enable low at the end of INCREMENT drops the event
        p_sig[4]  = 4'h2; p_clr[4]  = 4'h0; p_en[4]  = 1'b1; p_exp[4]  = 16'h0000;
        p_sig[5]  = 4'h0; p_clr[5]  = 4'h0; p_en[5]  = 1'b1; p_exp[5]  = 16'h0010;
        p_sig[6]  = 4'h2; p_clr[6]  = 4'h0; p_en[6]  = 1'b1; p_exp[6]  = 16'h0010;
        p_sig[7]  = 4'h0; p_clr[7]  = 4'h0; p_en[7]  = 1'b0; p_exp[7]  = 16'h0010;
        p_sig[8]  = 4'h0; p_clr[8]  = 4'h0; p_en[8]  = 1'b1; p_exp[8]  = 16'h0010;
        // simultaneous events on every channel
        p_sig[9]  = 4'hF; p_clr[9]  = 4'h0; p_en[9]  = 1'b1; p_exp[9]  = 16'h0010;
        p_sig[10] = 4'h0; p_clr[10] = 4'h0; p_en[10] = 1'b1; p_exp[10] = 16'h1121;
        // standalone clear of an idle channel
        p_sig[11] = 4'h0; p_clr[11] = 4'h1; p_en[11] = 1'b1; p_exp[11] = 16'h1120;
        p_sig[12] = 4'h0; p_clr[12] = 4'h0; p_en[12] = 1'b1; p_exp[12] = 16'h1120;
        for (int c = 0; c < 13; c++) begin
            sig_a = p_sig[c];
            clr_a = p_clr[c];
            en    = p_en[c];
            exp_q.push_back({4'h0, p_exp[c]});
            @(negedge pclk);
            obs_v = {tc_a, cnt_a};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL priority c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
        end
        clr_a = '0;
        en    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_debounce();
        test_wrap();
        test_saturate();
        test_priority();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
